// File: rtl/rr_resource_arbiter_pkg.sv
// Shared FSM encoding, default sizing and watchdog width for the round-robin
// resource arbiter.
package rr_resource_arbiter_pkg;

  localparam int DEF_N       = 4;
  localparam int DEF_TIMEOUT = 16;
  // Wide enough for the largest legal TIMEOUT (255).
  localparam int WD_W        = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_resource_arbiter_if.sv
// Request/grant handshake between requesters, the shared resource and the arbiter.
interface rr_resource_arbiter_if
  import rr_resource_arbiter_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int IDX_W = 2
);

  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             start;
  logic             busy;
  logic             abort;

  modport master (
    output req, done,
    input  grant, grant_idx, start, busy, abort
  );

  modport slave (
    input  req, done,
    output grant, grant_idx, start, busy, abort
  );

endinterface

// File: rtl/rr_ptr_counter.sv
// Round-robin pointer: a mod-N counter that jumps to one past the last
// granted index whenever a grant is released.
module rr_ptr_counter
  import rr_resource_arbiter_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [IDX_W-1:0] load_val,
  output logic [IDX_W-1:0] count
);

  logic [IDX_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      // Explicit wrap so a non-power-of-two N never reaches N.
      count_d = (load_val == IDX_W'(N - 1)) ? '0 : load_val + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter granting one shared resource to N requesters, with a
// start pulse per transaction and a watchdog that forces release on timeout.
module rr_resource_arbiter
  import rr_resource_arbiter_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  rr_resource_arbiter_if.slave  bus
);

  localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

  state_t           state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [N-1:0]     grant_q, grant_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             abort_q, abort_d;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             ptr_load;
  logic             timeout;

  rr_ptr_counter #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_ptr (
    .clk      (clk),
    .reset    (reset),
    .load     (ptr_load),
    .load_val (grant_idx_q),
    .count    (ptr)
  );

  // Scan from ptr upward; descending k lets the closest candidate win last.
  always_comb begin
    logic [IDX_W:0] cand;
    pick_idx = '0;
    cand     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (cand >= N_W) begin
        cand = cand - N_W;
      end
      if (bus.req[cand[IDX_W-1:0]]) begin
        pick_idx = cand[IDX_W-1:0];
      end
    end
  end

  // Outputs are registered, so release has to be decided while the counter
  // still reads TIMEOUT-2; abort then lands TIMEOUT-1 cycles after start.
  assign timeout = (wd_q == WD_W'(TIMEOUT - 2));

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    grant_idx_d = grant_idx_q;
    busy_d      = busy_q;
    start_d     = 1'b0;
    abort_d     = 1'b0;
    ptr_load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d     = ISSUE;
          grant_idx_d = pick_idx;
          busy_d      = 1'b1;
          start_d     = 1'b1;
          wd_d        = '0;
        end
      end
      ISSUE, WAIT: begin
        wd_d = wd_q + 1'b1;
        if (bus.done || timeout) begin
          state_d     = IDLE;
          grant_idx_d = '0;
          busy_d      = 1'b0;
          ptr_load    = 1'b1;
          abort_d     = ~bus.done;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d     = IDLE;
        grant_idx_d = '0;
        busy_d      = 1'b0;
      end
    endcase
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_grant
    assign grant_d[gi] = busy_d && (grant_idx_d == IDX_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      grant_idx_q <= '0;
      grant_q     <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      grant_idx_q <= grant_idx_d;
      grant_q     <= grant_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      abort_q     <= abort_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.start     = start_q;
  assign bus.busy      = busy_q;
  assign bus.abort     = abort_q;

endmodule
